spi_cmd_decoder: RTL

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_decoder_pkg.sv | 44 ++++
 rtl/spi_cmd_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for spi_cmd_decoder: opcodes, FSM states, idle MISO marker
// and byte helpers. Defining SPI_CMD_CHECKSUM_EN adds the CHK state.
package spi_cmd_decoder_pkg;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_WRITE_REG   = 8'h01;
    localparam logic [7:0] OP_READ_REG    = 8'h02;
    localparam logic [7:0] OP_WRITE_BLOCK = 8'h03;

    localparam logic [7:0] IDLE_MARKER    = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_RD_HI   = 3'd4,
        S_RD_LO   = 3'd5,
        S_DISCARD = 3'd6
`ifdef SPI_CMD_CHECKSUM_EN
        ,
        S_CHK     = 3'd7
`endif
    } state_t;

    // Error counter increment that sticks at 0xFF.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    function automatic logic [7:0] cmd_checksum(input logic [7:0] op,
                                                input logic [7:0] addr,
                                                input logic [7:0] hi,
                                                input logic [7:0] lo);
        return op ^ addr ^ hi ^ lo;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder.sv
// Byte-level SPI command decoder: turns opcode/address/data frames into register
// strobes and streams read data back. SPI_CMD_CHECKSUM_EN adds a WRITE_REG checksum.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              frame_active,
    output logic [7:0]        tx_byte,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            state_r, state_s;
    logic [7:0]        opcode_r, opcode_s;
    logic [ADDR_W-1:0] ptr_r, ptr_s;
    logic [7:0]        hi_r, hi_s;
    logic              rd_pend_r;
    logic [DATA_W-1:0] rd_data_r, rd_data_s;
    logic              wr_en_s, rd_en_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [7:0]        tx_s, err_s;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]        lo_r, lo_s;
    logic [7:0]        addr_byte_r, addr_byte_s;
`endif

    // Next-state and next-output decode for one received byte or a frame end.
    always_comb begin
        state_s   = state_r;
        opcode_s  = opcode_r;
        ptr_s     = ptr_r;
        hi_s      = hi_r;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        addr_s    = reg_addr;
        wr_data_s = reg_wr_data;
        err_s     = err_count;
`ifdef SPI_CMD_CHECKSUM_EN
        lo_s        = lo_r;
        addr_byte_s = addr_byte_r;
`endif
        // Read data arrives one cycle after the strobe; capture it then.
        if (rd_pend_r) begin
            rd_data_s = reg_rd_data;
        end else begin
            rd_data_s = rd_data_r;
        end

        if (!frame_active) begin
            state_s = S_IDLE;
            case (state_r)
                S_DATA_LO: err_s = sat_inc8(err_count);
`ifdef SPI_CMD_CHECKSUM_EN
                S_CHK:     err_s = sat_inc8(err_count);
`endif
                default:   err_s = err_count;
            endcase
        end else if (rx_valid) begin
            case (state_r)
                S_IDLE: begin
                    opcode_s = rx_byte;
                    case (rx_byte)
                        OP_WRITE_REG, OP_READ_REG, OP_WRITE_BLOCK: state_s = S_ADDR;
                        OP_NOP:  state_s = S_DISCARD;
                        default: begin
                            state_s = S_DISCARD;
                            err_s   = sat_inc8(err_count);
                        end
                    endcase
                end
                S_ADDR: begin
                    ptr_s = rx_byte[ADDR_W-1:0];
`ifdef SPI_CMD_CHECKSUM_EN
                    addr_byte_s = rx_byte;
`endif
                    if (opcode_r == OP_READ_REG) begin
                        state_s = S_RD_HI;
                        rd_en_s = 1'b1;
                        addr_s  = rx_byte[ADDR_W-1:0];
                    end else begin
                        state_s = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_s    = rx_byte;
                    state_s = S_DATA_LO;
                end
                S_DATA_LO: begin
`ifdef SPI_CMD_CHECKSUM_EN
                    if (opcode_r == OP_WRITE_REG) begin
                        lo_s    = rx_byte;
                        state_s = S_CHK;
                    end else begin
                        wr_en_s   = 1'b1;
                        addr_s    = ptr_r;
                        wr_data_s = {hi_r, rx_byte};
                        ptr_s     = ptr_r + PTR_ONE;
                        state_s   = S_DATA_HI;
                    end
`else
                    wr_en_s   = 1'b1;
                    addr_s    = ptr_r;
                    wr_data_s = {hi_r, rx_byte};
                    ptr_s     = ptr_r + PTR_ONE;
                    if (opcode_r == OP_WRITE_BLOCK) begin
                        state_s = S_DATA_HI;
                    end else begin
                        state_s = S_DISCARD;
                    end
`endif
                end
`ifdef SPI_CMD_CHECKSUM_EN
                S_CHK: begin
                    state_s = S_DISCARD;
                    if (rx_byte == cmd_checksum(opcode_r, addr_byte_r, hi_r, lo_r)) begin
                        wr_en_s   = 1'b1;
                        addr_s    = ptr_r;
                        wr_data_s = {hi_r, lo_r};
                        ptr_s     = ptr_r + PTR_ONE;
                    end else begin
                        err_s = sat_inc8(err_count);
                    end
                end
`endif
                S_RD_HI: state_s = S_RD_LO;
                S_RD_LO: begin
                    ptr_s   = ptr_r + PTR_ONE;
                    rd_en_s = 1'b1;
                    addr_s  = ptr_r + PTR_ONE;
                    state_s = S_RD_HI;
                end
                S_DISCARD: state_s = S_DISCARD;
                default:   state_s = S_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end

        case (state_s)
            S_RD_HI: tx_s = rd_data_s[15:8];
            S_RD_LO: tx_s = rd_data_s[7:0];
            default: tx_s = IDLE_MARKER;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_r    <= 8'h00;
            ptr_r       <= '0;
            hi_r        <= 8'h00;
            rd_pend_r   <= 1'b0;
            rd_data_r   <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            tx_byte     <= IDLE_MARKER;
            err_count   <= 8'h00;
`ifdef SPI_CMD_CHECKSUM_EN
            lo_r        <= 8'h00;
            addr_byte_r <= 8'h00;
`endif
        end else begin
            opcode_r    <= opcode_s;
            ptr_r       <= ptr_s;
            hi_r        <= hi_s;
            rd_pend_r   <= reg_rd_en;
            rd_data_r   <= rd_data_s;
            reg_wr_en   <= wr_en_s;
            reg_rd_en   <= rd_en_s;
            reg_addr    <= addr_s;
            reg_wr_data <= wr_data_s;
            tx_byte     <= tx_s;
            err_count   <= err_s;
`ifdef SPI_CMD_CHECKSUM_EN
            lo_r        <= lo_s;
            addr_byte_r <= addr_byte_s;
`endif
        end
    end

endmodule
